// File: rtl/mips_run_pkg.sv
// Shared types and constants for the MIPS run controller and its per-core halt detectors.
package mips_run_pkg;
    localparam int PC_W = 32;

    typedef enum logic [1:0] {RST_HOLD, RUN, DRAIN, DONE} run_state_t;

    // How a run finished, for reporting by whoever watches done/timeout.
    localparam logic [1:0] END_HALT    = 2'd1;
    localparam logic [1:0] END_TIMEOUT = 2'd2;
endpackage

// File: rtl/mips_halt_detect.sv
// Per-core halt detector: flags a core whose valid PC repeats STALL_LIMIT times in a row.
module mips_halt_detect
    import mips_run_pkg::*;
#(
    parameter int STALL_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    input  logic            pc_valid,
    input  logic [PC_W-1:0] pc,
    output logic            halted
);
    localparam int SC_W = $clog2(STALL_LIMIT);
    localparam logic [SC_W-1:0] SAT = SC_W'(STALL_LIMIT - 1);
    localparam logic [SC_W-1:0] PRE = SC_W'(STALL_LIMIT - 2);

    logic [PC_W-1:0] last_pc_reg;
    logic            seen_reg;
    logic [SC_W-1:0] same_cnt_reg;
    logic            halted_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            last_pc_reg  <= '0;
            seen_reg     <= 1'b0;
            same_cnt_reg <= '0;
            halted_reg   <= 1'b0;
        end else if (enable && pc_valid) begin
            if (!seen_reg) begin
                last_pc_reg  <= pc;
                seen_reg     <= 1'b1;
                same_cnt_reg <= '0;
            end else if (pc == last_pc_reg) begin
                if (same_cnt_reg != SAT)
                    same_cnt_reg <= same_cnt_reg + 1'b1;
                // Flag on the repeat that brings the count to SAT.
                if (same_cnt_reg >= PRE)
                    halted_reg <= 1'b1;
            end else begin
                // A moving PC restarts the count but never un-halts the core.
                last_pc_reg  <= pc;
                same_cnt_reg <= '0;
            end
        end
    end

    assign halted = halted_reg;
endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller: holds cores in reset, runs them with a cycle budget, and ends on
// all-cores-halted (after a drain window) or on timeout.
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int NUM_CORES    = 1,
    parameter int RST_CYCLES   = 2,
    parameter int MAX_CYCLES   = 1000,
    parameter int STALL_LIMIT  = 4,
    parameter int DRAIN_CYCLES = 8,
    parameter int CNT_W        = $clog2(MAX_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_CORES-1:0]      pc_valid,
    input  logic [PC_W*NUM_CORES-1:0] pc,
    output logic                      core_reset,
    output logic                      running,
    output logic                      done,
    output logic                      timeout,
    output logic [NUM_CORES-1:0]      halted,
    output logic [CNT_W-1:0]          cycle_count
);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [RW-1:0]    RST_LAST   = RW'(RST_CYCLES - 1);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MAX_CYCLES - 1);

    run_state_t       state_reg;
    logic [RW-1:0]    rst_cnt_reg;
    logic [DW-1:0]    drain_cnt_reg;
    logic             core_reset_reg;
    logic             running_reg;
    logic             done_reg;
    logic             timeout_reg;
    logic [CNT_W-1:0] cycle_count_reg;

    // Detectors are wiped on the relaunch edge too, so halted reads zero with the fresh RST_HOLD.
    logic det_clear;
    logic det_enable;
    assign det_clear  = (state_reg == RST_HOLD) || (state_reg == DONE && start);
    assign det_enable = (state_reg == RUN);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
            mips_halt_detect #(
                .STALL_LIMIT(STALL_LIMIT)
            ) u_detect (
                .clk     (clk),
                .reset   (reset),
                .clear   (det_clear),
                .enable  (det_enable),
                .pc_valid(pc_valid[gi]),
                .pc      (pc[PC_W*gi +: PC_W]),
                .halted  (halted[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= RST_HOLD;
            rst_cnt_reg     <= '0;
            drain_cnt_reg   <= '0;
            core_reset_reg  <= 1'b1;
            running_reg     <= 1'b0;
            done_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
            cycle_count_reg <= '0;
        end else begin
            case (state_reg)
                RST_HOLD: begin
                    if (rst_cnt_reg == RST_LAST) begin
                        state_reg      <= RUN;
                        core_reset_reg <= 1'b0;
                        running_reg    <= 1'b1;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + 1'b1;
                    end
                end
                RUN: begin
                    cycle_count_reg <= cycle_count_reg + 1'b1;
                    // All-halted takes priority over the budget in the same cycle.
                    if (&halted) begin
                        timeout_reg <= 1'b0;
                        if (DRAIN_CYCLES == 0) begin
                            state_reg   <= DONE;
                            running_reg <= 1'b0;
                            done_reg    <= 1'b1;
                        end else begin
                            state_reg     <= DRAIN;
                            drain_cnt_reg <= '0;
                        end
                    end else if (cycle_count_reg == CNT_LAST) begin
                        state_reg   <= DONE;
                        running_reg <= 1'b0;
                        done_reg    <= 1'b1;
                        timeout_reg <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        state_reg   <= DONE;
                        running_reg <= 1'b0;
                        done_reg    <= 1'b1;
                        timeout_reg <= 1'b0;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state_reg       <= RST_HOLD;
                        rst_cnt_reg     <= '0;
                        core_reset_reg  <= 1'b1;
                        done_reg        <= 1'b0;
                        timeout_reg     <= 1'b0;
                        cycle_count_reg <= '0;
                    end
                end
                default: state_reg <= RST_HOLD;
            endcase
        end
    end

    assign core_reset  = core_reset_reg;
    assign running     = running_reg;
    assign done        = done_reg;
    assign timeout     = timeout_reg;
    assign cycle_count = cycle_count_reg;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl; run-end and halt events are checked by a scoreboard monitor.
module tb_mips_run_ctrl;
    import mips_run_pkg::*;

    localparam int NC = 2;
    localparam int RC = 3;
    localparam int MC = 100;
    localparam int SL = 4;
    localparam int DC = 5;
    localparam int CW = $clog2(MC + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [NC-1:0] pc_valid = '0;
    logic [32*NC-1:0] pc = '0;
    logic          core_reset, running, done, timeout;
    logic [NC-1:0] halted;
    logic [CW-1:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    typedef struct {
        logic          tmo;
        logic [NC-1:0] hlt;
        int            cc;
        int            drain;
        string         name;
    } end_rec_t;

    end_rec_t      end_q[$];
    logic [NC-1:0] halt_q[$];

    always #5 clk = ~clk;

    mips_run_ctrl #(
        .NUM_CORES(NC), .RST_CYCLES(RC), .MAX_CYCLES(MC),
        .STALL_LIMIT(SL), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pc_valid(pc_valid), .pc(pc),
        .core_reset(core_reset), .running(running), .done(done), .timeout(timeout),
        .halted(halted), .cycle_count(cycle_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic cyc(input logic v0, input logic v1, input logic [31:0] p0, input logic [31:0] p1);
        pc_valid = {v1, v0};
        pc       = {p1, p0};
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_core_reset"}, core_reset, 1);
        check({tag, "_running"}, running, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
    endtask

    // Pulse start in DONE, then walk RST_HOLD into the first RUN cycle.
    task automatic launch(input string tag);
        start = 1'b1;
        cyc(0, 0, 0, 0);
        start = 1'b0;
        check({tag, "_relaunch_done"}, done, 0);
        check({tag, "_relaunch_halted"}, halted, 0);
        check({tag, "_relaunch_cc"}, cycle_count, 0);
        check({tag, "_relaunch_timeout"}, timeout, 0);
        check({tag, "_relaunch_core_reset"}, core_reset, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check({tag, "_hold_core_reset"}, core_reset, 1);
        cyc(0, 0, 0, 0);
        check({tag, "_run_entry_running"}, running, 1);
        check({tag, "_run_entry_core_reset"}, core_reset, 0);
    endtask

    // Scoreboard monitor: samples on the falling edge, pops on each run end and each new halt.
    int            streak = 0;
    int            streak_val = -1;
    int            frozen;
    logic          done_prev = 1'b0;
    logic [NC-1:0] halted_prev = '0;
    end_rec_t      er;
    logic [NC-1:0] eh;

    always @(negedge clk) begin
        if (armed) begin
            if (done && !done_prev) begin
                frozen = (streak_val == int'(cycle_count)) ? streak : 0;
                if (end_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    er = end_q.pop_front();
                    check({er.name, "_timeout"}, timeout, er.tmo);
                    check({er.name, "_halted"}, halted, er.hlt);
                    check({er.name, "_cycle_count"}, cycle_count, er.cc);
                    check({er.name, "_drain_len"}, frozen, er.drain);
                    $display("run %s end=%0d timeout=%0d halted=%b cycles=%0d drain=%0d",
                             er.name, timeout ? END_TIMEOUT : END_HALT, timeout, halted,
                             cycle_count, frozen);
                end
            end
            if (halted !== halted_prev && halted != '0) begin
                if (halt_q.size() == 0) begin
                    check("unexpected_halt", halted, 0);
                end else begin
                    eh = halt_q.pop_front();
                    check("halt_event", halted, eh);
                    $display("halt event halted=%b at cycle_count=%0d", halted, cycle_count);
                end
            end
            if (running) begin
                if (int'(cycle_count) == streak_val) streak++;
                else begin
                    streak_val = int'(cycle_count);
                    streak     = 1;
                end
            end else begin
                streak     = 0;
                streak_val = -1;
            end
            done_prev   = done;
            halted_prev = halted;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int k;
        logic [31:0] seq_pc [9];
        bit          seq_v  [9];

        // 1: reset hold timing and first RUN cycles
        reset = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        armed = 1'b1;
        check_reset_values("reset");
        reset = 1'b0;
        for (int i = 0; i < RC; i++) begin
            check("hold_core_reset", core_reset, 1);
            check("hold_running", running, 0);
            cyc(0, 0, 0, 0);
        end
        check("run_core_reset", core_reset, 0);
        check("run_running", running, 1);
        check("run_cc0", cycle_count, 0);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 0, 0);
            check("run_cc_step", cycle_count, i);
        end
        start = 1'b1;
        cyc(0, 0, 0, 0);
        start = 1'b0;
        check("start_ignored_running", running, 1);
        check("start_ignored_cc", cycle_count, 4);

        // 2: core0 halts at 0x3010 from cycle 20, core1 at 0x3020 from cycle 30
        halt_q.push_back(2'b01);
        halt_q.push_back(2'b11);
        end_q.push_back(end_rec_t'{1'b0, 2'b11, 35, DC, "two_core_halt"});
        k = 4;
        guard = 0;
        while (!done && guard < 200) begin
            cyc(1, 1, (k >= 20) ? 32'h3010 : 32'(32'h1000 + 4 * k),
                      (k >= 30) ? 32'h3020 : 32'(32'h2000 + 4 * k));
            k++;
            guard++;
        end
        check("t2_done_seen", done, 1);
        cyc(1, 1, 32'h9000, 32'h9004);
        cyc(1, 1, 32'h9008, 32'h900c);
        check("t2_cc_frozen", cycle_count, 35);
        check("t2_done_held", done, 1);

        // 3: PCs never repeat -> budget timeout
        launch("t3");
        end_q.push_back(end_rec_t'{1'b1, 2'b00, MC, 0, "timeout"});
        k = 0;
        while (!done && k < 150) begin
            cyc(1, 1, 32'(32'h4000 + 4 * k), 32'(32'h5000 + 4 * k));
            k++;
        end
        check("t3_run_len", k, MC);

        // 4: bubbles neither extend nor break a stall; a moving PC resets the count
        launch("t4");
        halt_q.push_back(2'b01);
        end_q.push_back(end_rec_t'{1'b1, 2'b01, MC, 0, "sticky_halt"});
        seq_pc = '{32'h3010, 32'h3010, 32'h3010, 32'h3014, 32'h3014,
                   32'h3014, 32'h3014, 32'h3014, 32'h3014};
        seq_v  = '{1, 1, 1, 1, 1, 1, 0, 0, 1};
        for (int i = 0; i < 9; i++) begin
            cyc(seq_v[i], 1, seq_pc[i], 32'(32'h5000 + 4 * i));
            if (i == 3) check("t4_moved_not_halted", halted, 2'b00);
            if (i == 7) check("t4_bubbles_not_halted", halted, 2'b00);
        end
        check("t4_halted_after_bubbles", halted, 2'b01);
        k = 9;
        while (!done && k < 150) begin
            cyc(1, 1, 32'(32'h6000 + 4 * k), 32'(32'h5000 + 4 * k));
            k++;
        end
        check("t4_done_seen", done, 1);

        // 5: all-halt seen in the cycle cycle_count is 99 -> drain wins over budget
        launch("t5");
        halt_q.push_back(2'b11);
        end_q.push_back(end_rec_t'{1'b0, 2'b11, MC, DC, "halt_at_budget"});
        k = 0;
        while (!done && k < 150) begin
            if (k >= 95) cyc(1, 1, 32'h7000, 32'h7000);
            else         cyc(1, 1, 32'(32'h1000 + 4 * k), 32'(32'h2000 + 4 * k));
            k++;
        end
        check("t5_done_seen", done, 1);

        // 6: reset in the middle of DRAIN abandons the run
        launch("t6");
        halt_q.push_back(2'b11);
        for (int i = 0; i < 7; i++) cyc(1, 1, 32'h8000, 32'h8000);
        check("t6_in_drain_running", running, 1);
        check("t6_in_drain_cc", cycle_count, 5);
        check("t6_in_drain_done", done, 0);
        reset = 1'b1;
        cyc(1, 1, 32'h8000, 32'h8000);
        check_reset_values("t6_mid_drain_reset");
        reset = 1'b0;
        for (int i = 0; i < RC; i++) cyc(0, 0, 0, 0);
        check("t6_rerun_running", running, 1);
        check("t6_rerun_cc", cycle_count, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        check("sb_end_queue_empty", end_q.size(), 0);
        check("sb_halt_queue_empty", halt_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
